// File: rtl/sub_div_ctrl.sv
// rtl/sub_div_ctrl.sv - multi-cycle restoring divider, one quotient bit per clock
module sub_div_ctrl #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] dividend,
    input  logic [n-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder,
    output logic         div0
);
    localparam int cw = $clog2(n);

    typedef enum logic [1:0] {
        s_idle,
        s_calc,
        s_done
    } state_t;

    state_t        state;
    logic [n-1:0]  acc;     // dividend bits leave at the MSB, quotient bits enter at the LSB
    logic [n-1:0]  dvsr;
    logic [n:0]    prem;
    logic [cw-1:0] cnt;

    logic [n:0]    shifted;
    logic [n+1:0]  sub;
    logic          borrow;
    logic          qbit;
    logic [n:0]    next_prem;
    logic          unused_prem_msb;

    // The one shared subtractor; the extra top bit is the borrow-out.
    assign shifted   = {prem[n-1:0], acc[n-1]};
    assign sub       = {1'b0, shifted} - {2'b00, dvsr};
    assign borrow    = sub[n+1];
    assign qbit      = ~borrow;
    assign next_prem = borrow ? shifted : sub[n:0];

    // A restoring remainder stays below the divisor, so its top bit is always zero.
    assign unused_prem_msb = prem[n] ^ next_prem[n];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= s_idle;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div0      <= 1'b0;
            cnt       <= '0;
            prem      <= '0;
            acc       <= '0;
            dvsr      <= '0;
        end else begin
            case (state)
                s_idle: begin
                    if (start) begin
                        if (divisor != '0) begin
                            acc   <= dividend;
                            dvsr  <= divisor;
                            prem  <= '0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= s_calc;
                        end else begin
                            quotient  <= '1;
                            remainder <= dividend;
                            div0      <= 1'b1;
                            done      <= 1'b1;
                            state     <= s_done;
                        end
                    end
                end
                s_calc: begin
                    prem <= next_prem;
                    acc  <= {acc[n-2:0], qbit};
                    if (cnt == cw'(n - 1)) begin
                        quotient  <= {acc[n-2:0], qbit};
                        remainder <= next_prem[n-1:0];
                        div0      <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= s_done;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                s_done: begin
                    done  <= 1'b0;
                    state <= s_idle;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= s_idle;
                end
            endcase
        end
    end
endmodule
